// File: rtl/id_scoreboard_pkg.sv
// Shared constants for the decode-stage RAW scoreboard.
// Register count, counter width and register address width.
package id_scoreboard_pkg;

    localparam int SB_NREG  = 32;
    localparam int SB_CNT_W = 2;
    localparam int REG_AW   = 5;

endpackage

// File: rtl/id_scoreboard.sv
// Decode-stage read-after-write interlock: one pending-write counter per GPR.
// Stalls ID while a source has an in-flight writer or the destination counter is full.
module id_scoreboard
    import id_scoreboard_pkg::*;
#(
    parameter int NREG  = SB_NREG,
    parameter int CNT_W = SB_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              src1_used,
    input  logic [REG_AW-1:0] src1_addr,
    input  logic              src2_used,
    input  logic [REG_AW-1:0] src2_addr,
    input  logic              dst_we,
    input  logic [REG_AW-1:0] dst_addr,
    input  logic              issue_fire,
    input  logic              retire_we,
    input  logic [REG_AW-1:0] retire_addr,
    output logic              ds_stall,
    output logic [NREG-1:0]   busy_vec
);

    logic                        issue_inc;
    logic                        retire_dec;
    logic [NREG-1:0][CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]            cnt_src1;
    logic [CNT_W-1:0]            cnt_src2;
    logic [CNT_W-1:0]            cnt_dst;

    assign issue_inc  = issue_fire & dst_we & (dst_addr != '0);
    assign retire_dec = retire_we & (retire_addr != '0);

    for (genvar i = 0; i < NREG; i++) begin : g_cnt
        if (i == 0) begin : g_zero
            assign cnt[i] = '0;
        end else begin : g_reg
            logic             inc;
            logic             dec;
            logic [CNT_W-1:0] q;

            assign inc = issue_inc & (dst_addr == REG_AW'(i));
            assign dec = retire_dec & (retire_addr == REG_AW'(i));

            // Same-cycle issue and retire cancel; a retire at zero holds.
            always_ff @(posedge clk) begin
                if (reset) begin
                    q <= '0;
                end else if (inc & ~dec) begin
                    q <= q + CNT_W'(1);
                end else if (dec & ~inc & (q != '0)) begin
                    q <= q - CNT_W'(1);
                end
            end

            assign cnt[i] = q;
        end
        assign busy_vec[i] = |cnt[i];
    end

    assign cnt_src1 = cnt[src1_addr];
    assign cnt_src2 = cnt[src2_addr];
    assign cnt_dst  = cnt[dst_addr];

    // No write-through: a source retiring this cycle still stalls.
    assign ds_stall = (src1_used & (src1_addr != '0) & (cnt_src1 != '0))
                    | (src2_used & (src2_addr != '0) & (cnt_src2 != '0))
                    | (dst_we & (dst_addr != '0) & (cnt_dst == '1));

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && retire_dec && (cnt[retire_addr] == '0)) begin
            $error("id_scoreboard: retire of r%0d with no pending write",
                   retire_addr);
        end
    end
`endif

endmodule

// File: tb/tb_id_scoreboard.sv
// Randomized scoreboard bench for id_scoreboard against a pending-count model.
// Driver pushes expected outputs per cycle; monitor pops and compares.
module tb_id_scoreboard;
    import id_scoreboard_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        src1_used = 1'b0;
    logic [4:0]  src1_addr = '0;
    logic        src2_used = 1'b0;
    logic [4:0]  src2_addr = '0;
    logic        dst_we = 1'b0;
    logic [4:0]  dst_addr = '0;
    logic        issue_fire = 1'b0;
    logic        retire_we = 1'b0;
    logic [4:0]  retire_addr = '0;
    logic        ds_stall;
    logic [31:0] busy_vec;

    int          pend [32];
    int          vectors = 0;
    int          miscompares = 0;
    logic [32:0] expq [$];

    always #5 clk = ~clk;

    id_scoreboard dut (
        .clk        (clk),
        .reset      (reset),
        .src1_used  (src1_used),
        .src1_addr  (src1_addr),
        .src2_used  (src2_used),
        .src2_addr  (src2_addr),
        .dst_we     (dst_we),
        .dst_addr   (dst_addr),
        .issue_fire (issue_fire),
        .retire_we  (retire_we),
        .retire_addr(retire_addr),
        .ds_stall   (ds_stall),
        .busy_vec   (busy_vec)
    );

    function automatic bit exp_stall(bit s1u, logic [4:0] s1a,
                                     bit s2u, logic [4:0] s2a,
                                     bit dwe, logic [4:0] da);
        bit st;
        st = (s1u && s1a != 0 && pend[s1a] > 0)
          || (s2u && s2a != 0 && pend[s2a] > 0)
          || (dwe && da != 0 && pend[da] == 3);
        return st;
    endfunction

    task automatic apply(input bit rst,
                         input bit s1u, input logic [4:0] s1a,
                         input bit s2u, input logic [4:0] s2a,
                         input bit dwe, input logic [4:0] da,
                         input bit fire,
                         input bit rwe, input logic [4:0] ra);
        logic [31:0] busy;
        bit          inc;
        bit          dec;
        @(negedge clk);
        reset       = rst;
        src1_used   = s1u;
        src1_addr   = s1a;
        src2_used   = s2u;
        src2_addr   = s2a;
        dst_we      = dwe;
        dst_addr    = da;
        issue_fire  = fire;
        retire_we   = rwe;
        retire_addr = ra;
        for (int i = 0; i < 32; i++) busy[i] = (pend[i] > 0);
        expq.push_back({exp_stall(s1u, s1a, s2u, s2a, dwe, da), busy});
        if (rst) begin
            for (int i = 0; i < 32; i++) pend[i] = 0;
        end else begin
            inc = fire && dwe && da != 0;
            dec = rwe && ra != 0;
            if (!(inc && dec && da == ra)) begin
                if (inc) pend[da] = pend[da] + 1;
                if (dec && pend[ra] > 0) pend[ra] = pend[ra] - 1;
            end
        end
    endtask

    task automatic idle();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic issue(input logic [4:0] d);
        apply(0, 0, 0, 0, 0, 1, d, 1, 0, 0);
    endtask

    task automatic retire(input logic [4:0] r);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1, r);
    endtask

    function automatic logic [4:0] pick();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            #2;
            vectors++;
            if (expq.size() == 0) begin
                miscompares++;
                $display("FAIL no_expect vec%0d: output present, none queued",
                         vectors);
            end else begin
                e = expq.pop_front();
                if ({ds_stall, busy_vec} !== e) begin
                    miscompares++;
                    $display("FAIL vec%0d stall/busy: got %b/%h want %b/%h",
                             vectors, ds_stall, busy_vec, e[32], e[31:0]);
                end
            end
        end
    end

    initial begin
        bit          s1u, s2u, dwe, fire, rwe, rst, st;
        logic [4:0]  s1a, s2a, da, ra;
        logic [4:0]  plist [$];
        for (int i = 0; i < 32; i++) pend[i] = 0;
        @(posedge clk);

        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) idle();

        issue(5);
        repeat (3) apply(0, 1, 5, 0, 0, 1, 6, 0, 0, 0);
        apply(0, 1, 5, 0, 0, 1, 6, 0, 1, 5);
        apply(0, 1, 5, 0, 0, 1, 6, 1, 0, 0);
        retire(6);

        issue(0);
        apply(0, 1, 0, 1, 0, 1, 0, 1, 0, 0);
        idle();

        repeat (3) issue(7);
        apply(0, 1, 2, 1, 3, 1, 7, 0, 0, 0);
        apply(0, 1, 2, 1, 3, 1, 7, 0, 1, 7);
        apply(0, 1, 2, 1, 3, 1, 7, 1, 0, 0);
        repeat (3) retire(7);
        idle();

        issue(9);
        apply(0, 0, 0, 0, 0, 1, 9, 1, 1, 9);
        issue(4);
        apply(0, 0, 0, 0, 0, 1, 3, 1, 1, 4);
        apply(0, 1, 9, 1, 3, 0, 0, 0, 1, 9);
        retire(3);
        idle();

        repeat (2) issue(12);
        apply(1, 1, 12, 0, 0, 0, 0, 0, 0, 0);
        apply(0, 1, 12, 0, 0, 0, 0, 0, 0, 0);
        idle();

        repeat (800) begin
            s1u  = 1'($urandom_range(0, 1));
            s1a  = pick();
            s2u  = 1'($urandom_range(0, 1));
            s2a  = pick();
            dwe  = ($urandom_range(0, 3) != 0);
            da   = pick();
            st   = exp_stall(s1u, s1a, s2u, s2a, dwe, da);
            fire = !st && ($urandom_range(0, 2) != 0);
            plist.delete();
            for (int i = 1; i < 32; i++)
                if (pend[i] > 0) plist.push_back(5'(i));
            rwe = 1'b0;
            ra  = '0;
            if (plist.size() > 0 && $urandom_range(0, 1) == 1) begin
                rwe = 1'b1;
                ra  = plist[$urandom_range(0, plist.size() - 1)];
            end else if ($urandom_range(0, 7) == 0) begin
                rwe = 1'b1;
            end
            rst = ($urandom_range(0, 149) == 0);
            apply(rst, s1u, s1a, s2u, s2a, dwe, da, fire, rwe, ra);
        end

        #3;
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
